fc_act_serializer: RTL and testbench
====================================

Name: fc_act_serializer

Overview:
- Egress side of an FC layer. Captures the parallel signed accumulator vector that an FC layer produces with a one-cycle valid.
- Applies optional ReLU, then round-and-saturate requantization to DATA_WIDTH.
- Streams the elements one per beat over a valid/ready handshake into the next FC layer's serial input (one element per valid).
- Flags vectors that are dropped because the upstream layer has no backpressure.

Parameters:
- NUM_NEURONS, 16, number of elements per input vector (>=2)
- ACC_WIDTH, 32, width of each signed accumulator input
- DATA_WIDTH, 16, width of each signed output element
- FRAC_BITS, 8, right-shift applied during requantization (0 allowed: no shift, no rounding)
- RELU_EN, 1, 1 = clamp negative accumulators to 0 before requantization

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- in_valid  in  1  single-cycle strobe; in_data is valid this cycle
- in_data  in  ACC_WIDTH x [NUM_NEURONS]  signed accumulator vector, unpacked array
- in_ready  out  1  vector can be captured this cycle
- out_valid  out  1  out_data holds a valid element
- out_ready  in  1  downstream accepts the element
- out_data  out  DATA_WIDTH  signed requantized element
- out_last  out  1  current element is index NUM_NEURONS-1
- overflow  out  1  sticky; a vector was dropped
- sat_cnt  out  16  saturating count of clipped elements

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE, idx=0, out_valid=0, out_last=0, overflow=0, sat_cnt=0.
  - Buffer contents are don't-care.
  - in_ready=0 while rst_n=0.
  - A reset during STREAM aborts the stream; no further beats are emitted.
- States:
  - IDLE: in_ready=1.
  - STREAM: in_ready = out_valid & out_ready & out_last, so a back-to-back vector can be captured on the final beat.
- Capture (in_valid & in_ready):
  - All NUM_NEURONS elements are requantized in parallel and stored as DATA_WIDTH values in the buffer.
  - Next cycle: state=STREAM, idx=0, out_valid=1.
  - Latency from capture edge to first valid beat is 1 cycle.
- Streaming:
  - out_data = buf[idx]; out_last = (idx==NUM_NEURONS-1).
  - out_valid, out_data and out_last hold stable while out_ready=0.
  - On a beat (out_valid & out_ready) with idx<NUM_NEURONS-1: idx increments.
  - On the last beat: if a capture happens the same cycle, stay in STREAM with idx=0 and out_valid=1. Otherwise go to IDLE with out_valid=0.
- Drop:
  - in_valid & !in_ready discards the vector and sets overflow=1.
  - overflow clears only on reset.
  - The current stream continues unaffected.
- Requantization, per element, computed in ACC_WIDTH+1 bits:
  - v = (RELU_EN && x<0) ? 0 : x.
  - If FRAC_BITS>0: r = (v + 2^(FRAC_BITS-1)) >>> FRAC_BITS, i.e. round half toward +inf. If FRAC_BITS=0: r = v.
  - Saturate r to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - The rounding add never wraps, including at x = max positive.
- Saturation count:
  - sat_cnt += (number of clipped elements in the captured vector) at each capture.
  - Sticks at 0xFFFF.
  - Dropped vectors are not counted.

Decomposition:
- Shared package fc_pkg:
  - default widths and FRAC_BITS;
  - state enum type (IDLE, STREAM);
  - sat_max/sat_min constant functions of DATA_WIDTH.
- Sub-module fc_requant: combinational, one element. Inputs x and RELU_EN; outputs DATA_WIDTH y and sat flag. Instantiated NUM_NEURONS times via generate.
- Top level holds the FSM, buffer, idx counter, overflow, sat_cnt and popcount of sat flags.

Test Plan (defaults unless stated):
- Rounding, RELU_EN=0:
  - in_data[0..3] = 384, 127, 128, -129 -> beats 2, 0, 1, -1.
  - in_data[4] = -128 -> 0.
  - out_last only on beat 15; sat_cnt=0.
- ReLU and saturation:
  - RELU_EN=1: in_data[0] = -256 -> 0.
  - RELU_EN=0: in_data[0] = -256 -> -1; 0x00FFFF00 -> 32767; 0x7FFFFFFF -> 32767 (no wrap); -0x01000000 -> -32768.
  - sat_cnt increments by 3 for that vector.
- Backpressure:
  - Random out_ready toggling: out_data/out_last stable while stalled.
  - Exactly 16 beats, in index order.
- Back-to-back and drop:
  - Second in_valid on the final beat with out_ready=1 -> captured; next cycle out_valid=1, idx=0, no bubble.
  - in_valid mid-stream -> dropped, overflow=1 and stays 1; current stream completes intact.
- Reset mid-stream:
  - Assert rst_n=0 at beat 5 -> next cycle out_valid=0, overflow=0, sat_cnt=0.
  - After release, a new vector streams from idx 0.
- FRAC_BITS=0, NUM_NEURONS=4:
  - in_data = 5, -7, 40000, -40000 (RELU_EN=0) -> 5, -7, 32767, -32768.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared widths, state type and saturation limits for the FC egress serializer.
package fc_pkg;

    localparam int FC_NUM_NEURONS = 16;
    localparam int FC_ACC_WIDTH   = 32;
    localparam int FC_DATA_WIDTH  = 16;
    localparam int FC_FRAC_BITS   = 8;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } fc_state_e;

    // Limits are returned as 64-bit values so callers can compare wider sums directly.
    function automatic longint sat_max(input int dw);
        return (longint'(1) <<< (dw - 1)) - longint'(1);
    endfunction

    function automatic longint sat_min(input int dw);
        return -(longint'(1) <<< (dw - 1));
    endfunction

endpackage

// File: rtl/fc_requant.sv
// One-element requantizer: optional ReLU, round half toward +inf, shift, then saturate.
module fc_requant
    import fc_pkg::*;
#(
    parameter int ACC_WIDTH  = FC_ACC_WIDTH,
    parameter int DATA_WIDTH = FC_DATA_WIDTH,
    parameter int FRAC_BITS  = FC_FRAC_BITS
) (
    input  logic signed [ACC_WIDTH-1:0]  x_i,
    input  logic                         relu_en_i,
    output logic signed [DATA_WIDTH-1:0] y_o,
    output logic                         sat_o
);

    localparam longint SMAX = sat_max(DATA_WIDTH);
    localparam longint SMIN = sat_min(DATA_WIDTH);

    logic signed [ACC_WIDTH:0] v;
    logic signed [ACC_WIDTH:0] r;
    longint                    rl;

    // One guard bit keeps the rounding add from wrapping at the most positive input.
    assign v = (relu_en_i && x_i[ACC_WIDTH-1]) ? '0 : {x_i[ACC_WIDTH-1], x_i};

    generate
        if (FRAC_BITS > 0) begin : g_round
            localparam logic signed [ACC_WIDTH:0] HALF = (ACC_WIDTH + 1)'(1) << (FRAC_BITS - 1);
            assign r = (v + HALF) >>> FRAC_BITS;
        end else begin : g_pass
            assign r = v;
        end
    endgenerate

    assign rl = longint'(r);

    always_comb begin
        y_o   = r[DATA_WIDTH-1:0];
        sat_o = 1'b0;
        if (rl > SMAX) begin
            y_o   = SMAX[DATA_WIDTH-1:0];
            sat_o = 1'b1;
        end else if (rl < SMIN) begin
            y_o   = SMIN[DATA_WIDTH-1:0];
            sat_o = 1'b1;
        end
    end

endmodule

// File: rtl/fc_act_serializer.sv
// FC layer egress: captures a parallel accumulator vector, requantizes it and streams
// the elements one per valid/ready beat, flagging vectors dropped for lack of room.
module fc_act_serializer
    import fc_pkg::*;
#(
    parameter int NUM_NEURONS = FC_NUM_NEURONS,
    parameter int ACC_WIDTH   = FC_ACC_WIDTH,
    parameter int DATA_WIDTH  = FC_DATA_WIDTH,
    parameter int FRAC_BITS   = FC_FRAC_BITS,
    parameter int RELU_EN     = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic signed [ACC_WIDTH-1:0]  in_data [NUM_NEURONS],
    output logic                         in_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         out_last,
    output logic                         overflow,
    output logic [15:0]                  sat_cnt
);

    localparam int IDXW = $clog2(NUM_NEURONS);
    localparam int CNTW = $clog2(NUM_NEURONS + 1);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_NEURONS - 1);

    fc_state_e                    state_q, state_d;
    logic [IDXW-1:0]              idx_q, idx_d;
    logic                         overflow_q, overflow_d;
    logic [15:0]                  sat_cnt_q, sat_cnt_d;
    logic signed [DATA_WIDTH-1:0] data_q [NUM_NEURONS];
    logic signed [DATA_WIDTH-1:0] req_y  [NUM_NEURONS];
    logic [NUM_NEURONS-1:0]       req_sat;
    logic [CNTW-1:0]              sat_num;
    logic [16:0]                  sat_sum;
    logic                         capture;
    logic                         beat;

    generate
        for (genvar g = 0; g < NUM_NEURONS; g++) begin : g_requant
            fc_requant #(
                .ACC_WIDTH (ACC_WIDTH),
                .DATA_WIDTH(DATA_WIDTH),
                .FRAC_BITS (FRAC_BITS)
            ) u_requant (
                .x_i      (in_data[g]),
                .relu_en_i(RELU_EN != 0),
                .y_o      (req_y[g]),
                .sat_o    (req_sat[g])
            );
        end
    endgenerate

    assign out_valid = (state_q == STREAM);
    assign out_last  = out_valid && (idx_q == LAST_IDX);
    assign out_data  = data_q[idx_q];
    assign beat      = out_valid && out_ready;
    // Accepting on the final beat lets a back-to-back vector stream with no bubble.
    assign in_ready  = rst_n && ((state_q == IDLE) || (beat && out_last));
    assign capture   = in_valid && in_ready;
    assign overflow  = overflow_q;
    assign sat_cnt   = sat_cnt_q;

    always_comb begin
        sat_num = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            sat_num = sat_num + CNTW'(req_sat[i]);
        end
    end

    assign sat_sum = {1'b0, sat_cnt_q} + 17'(sat_num);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        overflow_d = overflow_q | (in_valid & ~in_ready);
        sat_cnt_d  = sat_cnt_q;
        if (capture) begin
            state_d   = STREAM;
            idx_d     = '0;
            sat_cnt_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
        end else if (beat) begin
            if (out_last) begin
                state_d = IDLE;
                idx_d   = '0;
            end else begin
                idx_d = idx_q + IDXW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            overflow_q <= 1'b0;
            sat_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            overflow_q <= overflow_d;
            sat_cnt_q  <= sat_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            data_q <= req_y;
        end
    end

endmodule

// File: tb/tb_fc_act_serializer.sv
// Scoreboard bench: stimulus pushes hand-computed beats, per-DUT monitors pop and compare.
module tb_fc_act_serializer;

    localparam int N  = 16;
    localparam int NC = 4;
    localparam int AW = 32;
    localparam int DW = 16;

    typedef struct {
        int d;
        bit l;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                 aInValid, aInReady, aOutValid, aOutReady, aOutLast, aOverflow;
    logic signed [AW-1:0] aInData [N];
    logic signed [DW-1:0] aOutData;
    logic [15:0]          aSatCnt;

    logic                 bInValid, bInReady, bOutValid, bOutReady, bOutLast, bOverflow;
    logic signed [AW-1:0] bInData [N];
    logic signed [DW-1:0] bOutData;
    logic [15:0]          bSatCnt;

    logic                 cInValid, cInReady, cOutValid, cOutReady, cOutLast, cOverflow;
    logic signed [AW-1:0] cInData [NC];
    logic signed [DW-1:0] cOutData;
    logic [15:0]          cSatCnt;

    fc_act_serializer #(.NUM_NEURONS(N), .ACC_WIDTH(AW), .DATA_WIDTH(DW), .FRAC_BITS(8), .RELU_EN(0)) dutA (
        .clk(clk), .rst_n(rst_n), .in_valid(aInValid), .in_data(aInData), .in_ready(aInReady),
        .out_valid(aOutValid), .out_ready(aOutReady), .out_data(aOutData), .out_last(aOutLast),
        .overflow(aOverflow), .sat_cnt(aSatCnt));

    fc_act_serializer #(.NUM_NEURONS(N), .ACC_WIDTH(AW), .DATA_WIDTH(DW), .FRAC_BITS(8), .RELU_EN(1)) dutB (
        .clk(clk), .rst_n(rst_n), .in_valid(bInValid), .in_data(bInData), .in_ready(bInReady),
        .out_valid(bOutValid), .out_ready(bOutReady), .out_data(bOutData), .out_last(bOutLast),
        .overflow(bOverflow), .sat_cnt(bSatCnt));

    fc_act_serializer #(.NUM_NEURONS(NC), .ACC_WIDTH(AW), .DATA_WIDTH(DW), .FRAC_BITS(0), .RELU_EN(0)) dutC (
        .clk(clk), .rst_n(rst_n), .in_valid(cInValid), .in_data(cInData), .in_ready(cInReady),
        .out_valid(cOutValid), .out_ready(cOutReady), .out_data(cOutData), .out_last(cOutLast),
        .overflow(cOverflow), .sat_cnt(cSatCnt));

    exp_t qA[$], qB[$], qC[$];
    exp_t aExp, bExp, cExp;
    int   total = 0;
    int   bad = 0;
    int   aBeats = 0;
    logic aStall = 1'b0;
    logic signed [DW-1:0] aPrevData;
    logic aPrevLast;

    logic signed [AW-1:0] v1 [N], v2 [N], v3 [N], vj [N];
    int                   e1 [N], e2 [N], e3 [N];

    task automatic checkOutput(input string name, input logic signed [63:0] actual,
                               input logic signed [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic signed [AW-1:0] v [N], input int e [N],
                                 input bit expectCapture);
        aInData  = v;
        aInValid = 1'b1;
        if (expectCapture) begin
            for (int i = 0; i < N; i++) qA.push_back('{d: e[i], l: (i == N - 1)});
        end
    endtask

    task automatic drainA(input string name);
        for (int k = 0; k < 300 && qA.size() != 0; k++) tick();
        checkOutput(name, qA.size(), 0);
    endtask

    // Monitor A also checks that a stalled beat holds its data and last flag.
    always @(negedge clk) begin
        if (rst_n) begin
            if (aStall) begin
                checkOutput("A stall valid", aOutValid, 1);
                checkOutput("A stall data", aOutData, aPrevData);
                checkOutput("A stall last", aOutLast, aPrevLast);
            end
            if (aOutValid && aOutReady) begin
                if (qA.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL A unexpected beat: actual data=%0d required none", aOutData);
                end else begin
                    aExp = qA.pop_front();
                    checkOutput("A beat data", aOutData, aExp.d);
                    checkOutput("A beat last", aOutLast, aExp.l);
                end
                aBeats++;
            end
        end
        aStall    = rst_n && aOutValid && !aOutReady;
        aPrevData = aOutData;
        aPrevLast = aOutLast;
    end

    always @(negedge clk) begin
        if (rst_n && bOutValid && bOutReady) begin
            if (qB.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL B unexpected beat: actual data=%0d required none", bOutData);
            end else begin
                bExp = qB.pop_front();
                checkOutput("B beat data", bOutData, bExp.d);
                checkOutput("B beat last", bOutLast, bExp.l);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && cOutValid && cOutReady) begin
            if (qC.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL C unexpected beat: actual data=%0d required none", cOutData);
            end else begin
                cExp = qC.pop_front();
                checkOutput("C beat data", cOutData, cExp.d);
                checkOutput("C beat last", cOutLast, cExp.l);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  start;
        bit  dropped;
        bit  b2b;
        int  eb [N];
        int  ec [NC];

        for (int i = 0; i < N; i++) begin
            v1[i] = '0; v2[i] = '0; v3[i] = '0; vj[i] = 32'sh7FFFFFFF;
            e1[i] = 0;  e2[i] = 0;  e3[i] = 0;  eb[i] = 0;
            aInData[i] = '0; bInData[i] = '0;
        end
        for (int i = 0; i < NC; i++) cInData[i] = '0;
        v1[0] = 384;  e1[0] = 2;
        v1[1] = 127;  e1[1] = 0;
        v1[2] = 128;  e1[2] = 1;
        v1[3] = -129; e1[3] = -1;
        v1[4] = -128; e1[4] = 0;
        v1[15] = -384; e1[15] = -1;
        v2[0] = -256;          e2[0] = -1;
        v2[1] = 32'sh00FFFF00; e2[1] = 32767;
        v2[2] = 32'sh7FFFFFFF; e2[2] = 32767;
        v2[3] = -32'sh01000000; e2[3] = -32768;
        v3[0] = 8388352;       e3[0] = 32767;
        v3[1] = 8388480;       e3[1] = 32767;
        v3[2] = -8388736;      e3[2] = -32768;
        v3[3] = -8388737;      e3[3] = -32768;
        v3[4] = 32'sh80000000; e3[4] = -32768;
        v3[15] = 255;          e3[15] = 1;

        aInValid = 0; bInValid = 0; cInValid = 0;
        aOutReady = 0; bOutReady = 0; cOutReady = 0;
        repeat (3) tick();
        checkOutput("reset out_valid", aOutValid, 0);
        checkOutput("reset out_last", aOutLast, 0);
        checkOutput("reset overflow", aOverflow, 0);
        checkOutput("reset sat_cnt", aSatCnt, 0);
        checkOutput("reset in_ready", aInReady, 0);
        rst_n = 1'b1;
        #1;
        checkOutput("idle in_ready", aInReady, 1);

        // ReLU-enabled instance and the unshifted four-element instance run together.
        bInData[0] = -256;          eb[0] = 0;
        bInData[1] = -1;            eb[1] = 0;
        bInData[2] = 384;           eb[2] = 2;
        bInData[3] = 32'sh7FFFFFFF; eb[3] = 32767;
        bInData[15] = -5;           eb[15] = 0;
        cInData[0] = 5;      ec[0] = 5;
        cInData[1] = -7;     ec[1] = -7;
        cInData[2] = 40000;  ec[2] = 32767;
        cInData[3] = -40000; ec[3] = -32768;
        for (int i = 0; i < N; i++) qB.push_back('{d: eb[i], l: (i == N - 1)});
        for (int i = 0; i < NC; i++) qC.push_back('{d: ec[i], l: (i == NC - 1)});
        bOutReady = 1; cOutReady = 1; bInValid = 1; cInValid = 1;
        tick();
        bInValid = 0; cInValid = 0;
        checkOutput("B first beat latency", bOutValid, 1);
        checkOutput("C first beat latency", cOutValid, 1);
        for (int k = 0; k < 100 && (qB.size() + qC.size()) != 0; k++) tick();
        checkOutput("BC drained", qB.size() + qC.size(), 0);
        checkOutput("B sat_cnt", bSatCnt, 1);
        checkOutput("C sat_cnt", cSatCnt, 2);
        checkOutput("C idle after stream", cOutValid, 0);

        aOutReady = 1;
        applyStimulus(v1, e1, 1);
        tick();
        aInValid = 0;
        checkOutput("A first beat latency", aOutValid, 1);
        drainA("A v1 drained");
        checkOutput("A v1 sat_cnt", aSatCnt, 0);
        checkOutput("A idle after v1", aOutValid, 0);

        // Random stalls, a dropped vector mid-stream, then a capture on the final beat.
        applyStimulus(v2, e2, 1);
        tick();
        aInValid = 0;
        start = aBeats;
        dropped = 0;
        b2b = 0;
        for (int k = 0; k < 400 && !b2b; k++) begin
            if (aOutValid && aOutLast) begin
                aOutReady = 1;
                applyStimulus(v3, e3, 1);
                #1;
                checkOutput("A b2b in_ready", aInReady, 1);
                b2b = 1;
                tick();
                aInValid = 0;
                checkOutput("A b2b no bubble", aOutValid, 1);
                checkOutput("A b2b first data", aOutData, e3[0]);
            end else begin
                if (!dropped && (aBeats - start) >= 5) begin
                    applyStimulus(vj, e1, 0);
                    checkOutput("A drop in_ready", aInReady, 0);
                    dropped = 1;
                end
                aOutReady = 1'($urandom_range(0, 1));
                tick();
                aInValid = 0;
            end
        end
        checkOutput("A b2b reached", b2b, 1);
        aOutReady = 1;
        drainA("A v2/v3 drained");
        checkOutput("A overflow sticky", aOverflow, 1);
        checkOutput("A sat_cnt after v3", aSatCnt, 6);

        applyStimulus(v1, e1, 1);
        tick();
        aInValid = 0;
        start = aBeats;
        for (int k = 0; k < 50 && (aBeats - start) < 5; k++) tick();
        rst_n = 1'b0;
        tick();
        checkOutput("A abort out_valid", aOutValid, 0);
        checkOutput("A abort overflow", aOverflow, 0);
        checkOutput("A abort sat_cnt", aSatCnt, 0);
        checkOutput("A abort out_last", aOutLast, 0);
        qA.delete();
        rst_n = 1'b1;
        applyStimulus(v2, e2, 1);
        tick();
        aInValid = 0;
        drainA("A post-reset drained");
        checkOutput("A post-reset sat_cnt", aSatCnt, 3);
        checkOutput("A post-reset overflow", aOverflow, 0);

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
